// File: rtl/pe_fifo_feeder_pkg.sv
// Shared FSM type and sizing constants for the PE FIFO feeder.
// The optional stall counter is enabled by PE_FIFO_FEEDER_STALL_CNT_EN.
package pe_fifo_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } feeder_state_e;

    localparam int SKID_DEPTH      = 2;
    localparam int OCC_WIDTH       = $clog2(SKID_DEPTH + 1);
    localparam int STALL_CNT_WIDTH = 16;

    function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + STALL_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/pe_fifo_feeder_skid.sv
// Two-entry in-order skid buffer with registered occupancy; absorbs the
// GLB read that is still in flight when the PE FIFO asserts full.
module feeder_skid_buffer
    import pe_fifo_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq,
    input  logic [DATA_WIDTH-1:0] enq_data,
    input  logic                  deq,
    output logic [DATA_WIDTH-1:0] head,
    output logic [OCC_WIDTH-1:0]  occ
);

    localparam int PTR_WIDTH = $clog2(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_WIDTH-1:0]  occ_q, occ_d;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(SKID_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    always_comb begin
        // NOTE: every target gets a default first, so no path leaves a latch behind.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (enq) begin
            mem_d[wr_ptr_q] = enq_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (deq) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({enq, deq})
            2'b10:   occ_d = occ_q + OCC_WIDTH'(1);
            2'b01:   occ_d = occ_q - OCC_WIDTH'(1);
            default: occ_d = occ_q;
        endcase
    end

    // NOTE: flops use <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: storage is cleared too, so the head (and the feeder's data port) reads zero out of reset.
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign occ  = occ_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(enq && !deq && occ_q == OCC_WIDTH'(SKID_DEPTH)));
    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
        !(deq && occ_q == '0));

endmodule

// File: rtl/pe_fifo_feeder.sv
// Streams num_words GLB words (1-cycle read latency) into one PE input FIFO,
// honouring fifo_full via a 2-entry skid. Define PE_FIFO_FEEDER_STALL_CNT_EN for stall_cycles.
module pe_fifo_feeder
    import pe_fifo_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  push,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  fifo_full
`ifdef PE_FIFO_FEEDER_STALL_CNT_EN
    ,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
`endif
);

    feeder_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_rd_q, rem_rd_d;
    logic [LEN_WIDTH-1:0]  rem_push_q, rem_push_d;
    logic                  inflight_q, inflight_d;
    logic [OCC_WIDTH-1:0]  occ;
    logic [OCC_WIDTH:0]    occ_after;
    logic                  start_acc;

    assign start_acc = (state_q == ST_IDLE) && start;

    feeder_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .enq      (inflight_q),
        .enq_data (rd_data),
        .deq      (push),
        .head     (data),
        .occ      (occ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_words == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (push && rem_push_q == LEN_WIDTH'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A read may issue only if its word will still fit once it lands next cycle.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FINISH);
        push      = (occ != '0) && !fifo_full;
        occ_after = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight_q} - {{OCC_WIDTH{1'b0}}, push};
        rd_en     = (state_q == ST_RUN) && (rem_rd_q != '0)
                    && (occ_after < (OCC_WIDTH + 1)'(SKID_DEPTH));
    end

    assign rd_addr = addr_q;

    always_comb begin
        addr_d     = addr_q;
        rem_rd_d   = rem_rd_q;
        rem_push_d = rem_push_q;
        inflight_d = rd_en;
        if (start_acc) begin
            addr_d     = base_addr;
            rem_rd_d   = num_words;
            rem_push_d = num_words;
        end else begin
            if (rd_en) begin
                addr_d   = addr_q + ADDR_WIDTH'(1);
                rem_rd_d = rem_rd_q - LEN_WIDTH'(1);
            end
            if (push) begin
                rem_push_d = rem_push_q - LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            rem_rd_q   <= '0;
            rem_push_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            rem_rd_q   <= rem_rd_d;
            rem_push_q <= rem_push_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef PE_FIFO_FEEDER_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if (state_q == ST_RUN && occ != '0 && fifo_full) begin
            stall_d = sat_inc(stall_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pe_fifo_feeder.sv
// Self-checking bench for pe_fifo_feeder: cycle-exact vector table for clean
// streams, then scoreboarded directed and random transfers under backpressure.
module tb_pe_fifo_feeder;

    localparam int DW = 64;
    localparam int AW = 12;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] num_words;
    logic          busy, done, rd_en, push;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] data;
    logic          fifo_full;
`ifdef PE_FIFO_FEEDER_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    always #5 clk = ~clk;

    pe_fifo_feeder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .push      (push),
        .data      (data),
        .fifo_full (fifo_full)
`ifdef PE_FIFO_FEEDER_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every GLB address holds a distinct, recognisable word.
    function automatic logic [63:0] word_of(input logic [AW-1:0] a);
        return {20'hC0DE5, a, (32'(a) * 32'h9E37_79B9) + 32'h1234_5678};
    endfunction

    // GLB model: data valid the cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        if (rd_en) rd_data <= word_of(rd_addr);
        else       rd_data <= {$urandom, $urandom};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // fifo_full driver: 0 low, 1 toggle, 2 random, 3 window 3..7 after start, 4 table-held
    int   full_mode = 4;
    int   start_cyc = 0;
    logic tbl_full  = 1'b0;
    initial begin
        fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (full_mode)
                1:       fifo_full = ~fifo_full;
                2:       fifo_full = ($urandom_range(0, 2) == 0);
                3:       fifo_full = (cyc - start_cyc >= 3) && (cyc - start_cyc <= 7);
                4:       fifo_full = tbl_full;
                default: fifo_full = 1'b0;
            endcase
        end
    end

    // Transfer-level reference model: expected word stream plus event counters.
    logic [63:0]   exp_q[$];
    logic [AW-1:0] cur_base;
    int            cur_n, reads, pushes, done_cnt, last_push_cyc, occ_m, stall_m;
    logic          rd_last;
    bit            mon_en = 0;

    task automatic model_clear();
        exp_q.delete();
        cur_base = '0; cur_n = 0; reads = 0; pushes = 0;
        done_cnt = 0; stall_m = 0; last_push_cyc = -1; rd_last = 1'b0;
    endtask

    task automatic model_start(input logic [AW-1:0] b, input logic [LW-1:0] n);
        exp_q.delete();
        for (int i = 0; i < int'(n); i++) exp_q.push_back(word_of(AW'(b + AW'(i))));
        cur_base = b; cur_n = int'(n); reads = 0; pushes = 0;
        done_cnt = 0; stall_m = 0; last_push_cyc = -1;
    endtask

    // Words in the skid = reads issued at least two cycles ago minus words pushed.
    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) begin
                model_clear();
            end else begin
                occ_m = (reads - int'(rd_last)) - pushes;
                check("occ_bound", 64'(occ_m >= 0 && occ_m <= 2), 1);
                check("push_rule", push, (occ_m != 0) && !fifo_full);
                if (push) begin
                    check("push_expected", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check("push_data", data, exp_q.pop_front());
                    pushes++;
                    last_push_cyc = cyc;
                end
                if (rd_en) begin
                    check("rd_within_len", 64'(reads < cur_n), 1);
                    check("rd_addr", rd_addr, 64'(AW'(cur_base + AW'(reads))));
                    reads++;
                end
                if (busy && !done && occ_m != 0 && fifo_full && stall_m < 16'hFFFF) stall_m++;
                if (done) done_cnt++;
                rd_last = rd_en;
            end
        end
    end

    typedef struct packed {
        logic          rst, st;
        logic [AW-1:0] base;
        logic [LW-1:0] num;
        logic          full;
        logic          busy, done, rd, push;
        logic          chk_addr;
        logic [AW-1:0] addr;
        logic          chk_data;
        logic [63:0]   dat;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic rst, input logic st, input logic [AW-1:0] b, input logic [LW-1:0] n,
                           input logic b_busy, input logic b_done, input logic b_rd, input logic b_push,
                           input logic ca, input logic [AW-1:0] a, input logic cd, input logic [63:0] d);
        vec_t v;
        v = '{rst: rst, st: st, base: b, num: n, full: 1'b0, busy: b_busy, done: b_done, rd: b_rd,
              push: b_push, chk_addr: ca, addr: a, chk_data: cd, dat: d};
        tbl.push_back(v);
    endtask

    // Unstalled stream: reads in cycles 1..n, pushes 3..n+2, done n+3, idle n+4.
    task automatic add_stream(input logic [AW-1:0] b, input int n);
        add_vec(0, 1, b, LW'(n), 0, 0, 0, 0, 0, '0, 0, '0);
        for (int c = 1; c <= n + 4; c++) begin
            logic r, p;
            r = (c <= n);
            p = (c >= 3) && (c <= n + 2);
            add_vec(0, 0, b, LW'(n), c <= n + 3, c == n + 3, r, p,
                    r, AW'(b + AW'(c - 1)), p, word_of(AW'(b + AW'(c - 3))));
        end
    endtask

    task automatic run_transfer(input logic [AW-1:0] b, input logic [LW-1:0] n, input int mode,
                                input int budget, input int max_lat, input int ign_at);
        bit seen;
        int done_at;
        seen = 0;
        done_at = 0;
        start = 1'b1; base_addr = b; num_words = n;
        model_start(b, n);
        start_cyc = cyc;
        full_mode = mode;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                done_at = cyc;
            end else begin
                @(posedge clk);
                #1;
                if (i + 1 == ign_at) begin
                    start = 1'b1; base_addr = 12'h300; num_words = 12'd3;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("done_seen", 64'(seen), 1);
        @(posedge clk);
        #1;
        full_mode = 0;
        @(negedge clk);
        #1;
        check("busy_after_done", busy, 0);
        check("push_count", 64'(pushes), 64'(n));
        check("read_count", 64'(reads), 64'(n));
        check("words_left", 64'(exp_q.size()), 0);
        check("done_pulses", 64'(done_cnt), 1);
        if (n != 0) check("done_after_last_push", 64'(done_at), 64'(last_push_cyc + 1));
        if (max_lat > 0) check("latency_bound", 64'((done_at - start_cyc) <= max_lat), 1);
`ifdef PE_FIFO_FEEDER_STALL_CNT_EN
        check("stall_cycles", 64'(stall_cycles), 64'(stall_m));
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_rd;
        logic [LW-1:0] rn;
        reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;

        // Reset row, then reset values; basic stream; zero-length; wrapping stream.
        add_vec(1, 0, '0, '0, 0, 0, 0, 0, 0, '0, 0, '0);
        add_vec(0, 0, '0, '0, 0, 0, 0, 0, 1, '0, 1, '0);
        add_stream(12'h010, 4);
        add_vec(0, 1, 12'h123, '0, 0, 0, 0, 0, 0, '0, 0, '0);
        add_vec(0, 0, 12'h123, '0, 1, 1, 0, 0, 0, '0, 0, '0);
        add_vec(0, 0, 12'h123, '0, 0, 0, 0, 0, 0, '0, 0, '0);
        add_stream(12'hFFE, 4);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; start = tbl[i].st;
            base_addr = tbl[i].base; num_words = tbl[i].num; tbl_full = tbl[i].full;
            @(negedge clk);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            check($sformatf("vec%0d_done", i), done, tbl[i].done);
            check($sformatf("vec%0d_rd_en", i), rd_en, tbl[i].rd);
            check($sformatf("vec%0d_push", i), push, tbl[i].push);
            if (tbl[i].chk_addr) check($sformatf("vec%0d_rd_addr", i), rd_addr, tbl[i].addr);
            if (tbl[i].chk_data) check($sformatf("vec%0d_data", i), data, tbl[i].dat);
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        model_clear();
        mon_en = 1;
        full_mode = 0;

        // Backpressure window, ignored second start, toggling full.
        run_transfer(12'h040, 12'd8, 3, 100, 0, 0);
        run_transfer(12'h080, 12'd8, 0, 40, 11, 4);
        run_transfer(12'h7F0, 12'd32, 1, 200, 67, 0);

        // Reset one cycle after the third read of a 16-word transfer.
        start = 1'b1; base_addr = 12'h100; num_words = 12'd16;
        model_start(12'h100, 12'd16);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_rd = 0;
        for (int i = 0; i < 20 && n_rd < 3; i++) begin
            @(negedge clk);
            if (rd_en) n_rd++;
            @(posedge clk);
            #1;
        end
        check("reads_before_reset", 64'(n_rd), 3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_push", push, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_data", data, 0);
        @(posedge clk);
        #1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rst_no_done", 64'(done_cnt), 0);
        check("rst_no_push", 64'(pushes), 0);
        run_transfer(12'h200, 12'd2, 0, 40, 5, 0);

        // Random transfers under random or no backpressure.
        for (int k = 0; k < 12; k++) begin
            rn = LW'($urandom_range(0, 20));
            if (k % 3 == 0) run_transfer(AW'($urandom), rn, 0, 40, int'(rn) + 3, 0);
            else            run_transfer(AW'($urandom), rn, 2, 40 * int'(rn) + 40, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
